palette_port_arbiter: RTL
=========================

// Module: palette_port_arbiter
// PURPOSE
//  Shares the single-port 64x24 palette ROM/RAM (address/clock/q, 1-cycle read latency) between the
//  checkerboard pixel path (read, absolute priority) and a palette-update requester (write).
//  Writes are queued in a small FIFO and drained one per cycle only in blanking windows, so the
//  visible raster never sees a stalled or corrupted read. Sits between image generator and palette memory.
// PARAMETERS
//  FIFO_DEPTH    4  write-request queue entries (power of 2, 2..16)
//  VBLANK_ONLY   0  1: drain only in vertical blanking (after VS fall); 0: any cycle vid_req=0
//  ADDR_W        6  palette address width
//  DATA_W        24 palette word width {R[23:16],G[15:8],B[7:0]}
// PORTS
//  clk         in   1        VGA pixel clock; all logic on rising edge
//  rst         in   1        reset, synchronous, active-low
//  vs          in   1        vertical sync, active-low
//  vid_req     in   1        pixel path read request (IAA, visible area)
//  vid_addr    in   ADDR_W   pixel path read address
//  vid_q       out  DATA_W   read data, valid 1 cycle after vid_req
//  vid_q_vld   out  1        vid_req delayed 1 cycle
//  wr_valid    in   1        update request valid
//  wr_ready    out  1        queue can accept (=!full, registered)
//  wr_addr     in   ADDR_W   update address
//  wr_data     in   DATA_W   update data
//  mem_addr    out  ADDR_W   to palette memory
//  mem_we      out  1        palette write enable
//  mem_wdata   out  DATA_W   palette write data
//  mem_q       in   DATA_W   palette read data (1-cycle latency)
//  wr_pending  out  5        queue occupancy 0..FIFO_DEPTH
//  stall_cnt   out  16       cycles with queue non-empty and write blocked; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst=0 at edge): queue flushed, wr_pending=0, wr_ready=1, mem_we=0, vid_q_vld=0,
//   stall_cnt=0, window FSM -> CLOSED; an in-flight write is abandoned (mem_we low next cycle).
//  Arbitration is combinational per cycle: vid_req=1 -> mem_addr=vid_addr, mem_we=0, regardless of queue.
//  vid_req=0 and window open and queue non-empty -> mem_addr/mem_wdata=queue head, mem_we=1, pop.
//  Otherwise mem_addr=vid_addr, mem_we=0. One write per cycle max.
//  vid_q = mem_q passthrough; vid_q_vld registered from vid_req (read latency 1).
//  Push when wr_valid & wr_ready; wr_ready is low only when occupancy==FIFO_DEPTH.
//   Push and pop in same cycle: occupancy unchanged, legal at full (pop frees, ready reasserts next cycle).
//  Queue order strictly FIFO; same-address writes both land, last one wins.
//  Window FSM (VBLANK_ONLY=1): CLOSED -> OPEN on VS falling edge (vs 1->0 registered);
//   OPEN -> CLOSED on first cycle vid_req=1. Entries left at close stay queued for next frame.
//  VBLANK_ONLY=0: window is open whenever vid_req=0; FSM held in OPEN after reset exits.
//  stall_cnt increments when occupancy>0 and no pop that cycle (vid_req=1 or window closed).
//  wr_pending updates the cycle after push/pop; never exceeds FIFO_DEPTH, never underflows.
//  X on wr_addr/wr_data ignored while wr_valid=0.
// TESTING
//  1 Reset: hold rst=0 3 cycles with wr_valid=1 -> wr_pending=0, mem_we=0, stall_cnt=0, wr_ready=1.
//  2 VBLANK_ONLY=0, vid_req=0: push (addr 5,24'hFF0000) -> next cycle mem_we=1, mem_addr=5; pending 1->0.
//  3 vid_req=1 for 100 cycles with 3 queued writes -> mem_we stays 0, stall_cnt=100, vid_q_vld follows
//    vid_req by 1 cycle; on vid_req=0 three consecutive writes in push order.
//  4 Fill 4 writes while vid_req=1 -> wr_ready=0, 5th wr_valid ignored; release -> exactly 4 writes.
//  5 VBLANK_ONLY=1: queue 2 writes in blanking before VS fall -> no write; VS 1->0 -> both drain
//    in 2 cycles; write queued after vid_req rises waits for next VS fall.
//  6 Reset asserted mid-drain with 3 pending -> following cycle mem_we=0, pending=0; no later writes.

Source files
------------

// File: rtl/palette_port_arbiter.sv
// Shares a 1-cycle-latency palette memory: pixel reads always win, queued updates drain in blanking.
// Read data is a passthrough of mem_q; the update queue backpressures via registered wr_ready.
module palette_port_arbiter #(
  parameter int FIFO_DEPTH  = 4,
  parameter bit VBLANK_ONLY = 1'b0,
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_q,
  output logic              vid_q_vld,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q,
  output logic [4:0]        wr_pending,
  output logic [15:0]       stall_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {WIN_CLOSED, WIN_OPEN} win_state_e;

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             wr_ready_q, wr_ready_d;
  logic             vid_q_vld_q;
  logic             vs_q;
  logic [15:0]      stall_q, stall_d;
  win_state_e       win_q, win_d;

  logic push, pop, win_open, vs_fall, q_empty;

  assign q_empty  = (cnt_q == 5'd0);
  assign vs_fall  = vs_q & ~vs;
  assign win_open = VBLANK_ONLY ? (win_q == WIN_OPEN) : 1'b1;

  // Gating with rst drops a write that is in flight when reset arrives.
  assign push = rst & wr_valid & wr_ready_q;
  assign pop  = rst & ~vid_req & win_open & ~q_empty;

  always_comb begin
    win_d = win_q;
    if (!VBLANK_ONLY) begin
      win_d = WIN_OPEN;
    end else begin
      case (win_q)
        WIN_CLOSED: if (vs_fall) win_d = WIN_OPEN;
        WIN_OPEN:   if (vid_req) win_d = WIN_CLOSED;
        default:    win_d = WIN_CLOSED;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
    wr_ready_d = (cnt_d != 5'(FIFO_DEPTH));
    stall_d    = stall_q;
    if (!q_empty && !pop && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      wr_ready_q  <= 1'b1;
      vid_q_vld_q <= 1'b0;
      vs_q        <= 1'b1;
      stall_q     <= '0;
      win_q       <= WIN_CLOSED;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      wr_ready_q  <= wr_ready_d;
      vid_q_vld_q <= vid_req;
      vs_q        <= vs;
      stall_q     <= stall_d;
      win_q       <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr_q] <= wr_addr;
      q_data[wr_ptr_q] <= wr_data;
    end
  end

  assign mem_addr   = pop ? q_addr[rd_ptr_q] : vid_addr;
  assign mem_wdata  = q_data[rd_ptr_q];
  assign mem_we     = pop;
  assign vid_q      = mem_q;
  assign vid_q_vld  = vid_q_vld_q;
  assign wr_ready   = wr_ready_q;
  assign wr_pending = cnt_q;
  assign stall_cnt  = stall_q;

endmodule
